bit_serializer: RTL

Parallel-to-serial front end for the serial pattern-detection path. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `dout`, which drives the detector's `din` input directly. A `dout_valid` qualifier marks the bit slots that carry data. An optional prefetch register allows gap-free back-to-back streaming.

---
 rtl/bit_serializer_pkg.sv | 24 ++
 rtl/bit_serializer_hold_reg.sv | 43 ++++
 rtl/bit_serializer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// ============================================================================
// Module   : ser_pkg
// Brief    : Shared types, defaults and bit-select helper for bit_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int SER_DEFAULT_WIDTH = 8;

   // Position within the word of the bit emitted at slot `cnt`.
   function automatic int ser_bit_idx(input int cnt, input int width, input bit msb_first);
      return msb_first ? (width - 1 - cnt) : cnt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bit_serializer_hold_reg.sv
// ============================================================================
// Module   : ser_hold_reg
// Brief    : One-word prefetch holding register with full flag, load and take.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_hold_reg
   import ser_pkg::*;
#(
   parameter int WIDTH = SER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             take_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o
);

   logic [WIDTH-1:0] data_q;
   logic             full_q;

   // A load on the same edge as a take refills the slot, so load wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         full_q <= 1'b1;
      end else if (take_i) begin
         full_q <= 1'b0;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module   : bit_serializer
// Brief    : Valid/ready parallel-to-serial converter, one bit per clock.
//            Define BIT_SERIALIZER_PREFETCH_EN for gap-free back-to-back words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH     = SER_DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy
);

   localparam int                CNT_W      = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  C_LAST_CNT = CNT_W'(WIDTH - 1);

   ser_state_t       state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic             dout_q;
   logic             dout_valid_q;

   logic             handshake;
   logic             last_bit;
   logic [CNT_W-1:0] sel_idx;
   logic             cur_bit;

   assign handshake = in_valid && in_ready;
   assign last_bit  = (bit_cnt_q == C_LAST_CNT);
   assign sel_idx   = CNT_W'(ser_bit_idx(int'(bit_cnt_q), WIDTH, MSB_FIRST));
   assign cur_bit   = shreg_q[sel_idx];

`ifdef BIT_SERIALIZER_PREFETCH_EN
   logic             hold_full;
   logic [WIDTH-1:0] hold_data;
   logic             hold_load;
   logic             hold_take;

   // While shifting, accepted words park in hold unless the shifter is
   // finishing with an empty hold, in which case the word goes straight in.
   assign hold_load = handshake && (state_q == SHIFT) && (!last_bit || hold_full);
   assign hold_take = (state_q == SHIFT) && last_bit && hold_full;

   ser_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk    (clk),
      .rst    (rst),
      .load_i (hold_load),
      .data_i (in_data),
      .take_i (hold_take),
      .data_o (hold_data),
      .full_o (hold_full)
   );

   assign in_ready = !hold_full;
   assign busy     = (state_q == SHIFT) || hold_full;
`else
   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q == SHIFT);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               dout_q       <= 1'b0;
               dout_valid_q <= 1'b0;
               if (handshake) begin
                  shreg_q   <= in_data;
                  bit_cnt_q <= '0;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               dout_q       <= cur_bit;
               dout_valid_q <= 1'b1;
               if (last_bit) begin
`ifdef BIT_SERIALIZER_PREFETCH_EN
                  if (hold_full) begin
                     shreg_q   <= hold_data;
                     bit_cnt_q <= '0;
                  end else if (handshake) begin
                     shreg_q   <= in_data;
                     bit_cnt_q <= '0;
                  end else begin
                     state_q   <= IDLE;
                  end
`else
                  state_q <= IDLE;
`endif
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule

`default_nettype wire
